// File: rtl/mult_dispatch_pkg.sv
// Shared types and helpers for the app_mult operand dispatcher.
package mult_dispatch_pkg;

  localparam int unsigned DefW = 16;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StGuard,
    StWait,
    StHold
  } state_e;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mult_dispatch_fifo.sv
// Operand FIFO: DEPTH x DW storage with registered ready (not full) and empty flags.
module mult_dispatch_fifo
  import mult_dispatch_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [DW-1:0]           wdata_i,
  output logic [DW-1:0]           rdata_o,
  output logic                    ready_o,
  output logic [ptr_w(DEPTH):0]   count_o
);

  localparam int unsigned PW = ptr_w(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          ready_q, ready_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  assign do_push = push_i && ready_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (!do_push && do_pop) count_d = count_q - 1'b1;
    // Flags track the next count so they are valid straight out of the flop.
    ready_d = (count_d != (PW+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign ready_o = ready_q;
  assign count_o = count_q;

endmodule

// File: rtl/mult_dispatch.sv
// Dispatcher that feeds queued A/B pairs to app_mult one at a time and returns results in order.
// Optional Done timeout enabled by defining MULT_DISPATCH_TMO_EN.
module mult_dispatch
  import mult_dispatch_pkg::*;
#(
  parameter int unsigned W     = DefW,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TMO   = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_A,
  input  logic [W-1:0] in_B,
  output logic         start,
  output logic [W-1:0] A,
  output logic [W-1:0] B,
  input  logic         Done,
  input  logic [W-1:0] Result,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_err
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TMO < 1) begin : g_bad_param
    $error("mult_dispatch: DEPTH must be a power of 2 >= 2 and TMO >= 1");
  end

  state_e              state_q, state_d;
  logic [W-1:0]        a_q, a_d, b_q, b_d;
  logic                res_valid_q, res_valid_d;
  logic [W-1:0]        res_data_q, res_data_d;
  logic                fifo_pop;
  logic [2*W-1:0]      fifo_rdata;
  logic [ptr_w(DEPTH):0] fifo_count;

`ifdef MULT_DISPATCH_TMO_EN
  localparam int unsigned CntW = $clog2(TMO + 1);
  logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            res_err_q, res_err_d;
`endif

  mult_dispatch_fifo #(
    .DW    (2 * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .pop_i   (fifo_pop),
    .wdata_i ({in_A, in_B}),
    .rdata_o (fifo_rdata),
    .ready_o (in_ready),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    fifo_pop    = 1'b0;
    start       = 1'b0;
`ifdef MULT_DISPATCH_TMO_EN
    tmo_cnt_d   = tmo_cnt_q;
    res_err_d   = res_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (fifo_count != '0) begin
          fifo_pop   = 1'b1;
          {a_d, b_d} = fifo_rdata;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        start   = 1'b1;
        state_d = StGuard;
      end
      // Done may still be high from the previous op here, so it is not looked at.
      StGuard: begin
        state_d = StWait;
`ifdef MULT_DISPATCH_TMO_EN
        tmo_cnt_d = '0;
`endif
      end
      StWait: begin
        if (Done) begin
          res_data_d  = Result;
          res_valid_d = 1'b1;
          state_d     = StHold;
`ifdef MULT_DISPATCH_TMO_EN
          res_err_d   = 1'b0;
        end else if (tmo_cnt_q == CntW'(TMO - 1)) begin
          res_data_d  = '1;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = StHold;
        end else begin
          tmo_cnt_d   = tmo_cnt_q + 1'b1;
`endif
        end
      end
      StHold: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

`ifdef MULT_DISPATCH_TMO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      res_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      res_err_q <= res_err_d;
    end
  end

  assign res_err = res_err_q;
`else
  assign res_err = 1'b0;
`endif

  assign A         = a_q;
  assign B         = b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_mult_dispatch.sv
// Self-checking bench for mult_dispatch: vector table, corner sequences and random traffic.
module tb_mult_dispatch;

  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 64;
  localparam int MNormal = 0;
  localparam int MStuck  = 1;
  localparam int MDead   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_A = '0;
  logic [W-1:0]  in_B = '0;
  logic          start;
  logic [W-1:0]  A, B;
  logic          Done = 1'b0;
  logic [W-1:0]  Result = '0;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [W-1:0]  res_data;
  logic          res_err;

  always #5 clk = ~clk;

  mult_dispatch #(
    .W     (W),
    .DEPTH (DEPTH),
    .TMO   (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_A      (in_A),
    .in_B      (in_B),
    .start     (start),
    .A         (A),
    .B         (B),
    .Done      (Done),
    .Result    (Result),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle-time %0t)", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'(a) * longint'(b);
    return W'(p % 65536);
  endfunction

  // Multiplier / consumer model
  int          cyc = 0;
  int          mode = MNormal;
  int          mul_lat = 5;
  bit          rand_lat = 1'b0;
  int          rr_mode = 0;
  bit          spurious = 1'b0;
  bit          busy = 1'b0;
  int          cnt = 0;
  logic [W-1:0] prod = '0;
  int          done_cyc = -100;

  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      case (rr_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = 1'($urandom_range(0, 1));
        default: res_ready = 1'b0;
      endcase
      Done = 1'b0;
      if (rst) begin
        busy = 1'b0;
      end else if (mode == MStuck) begin
        Done   = 1'b1;
        Result = A * B;
      end else if (start) begin
        busy = (mode == MNormal);
        cnt  = rand_lat ? int'($urandom_range(2, 6)) : mul_lat;
        prod = A * B;
      end else if (busy) begin
        cnt--;
        if (cnt == 0) begin
          Done     = 1'b1;
          Result   = prod;
          busy     = 1'b0;
          done_cyc = cyc;
        end
      end else if (spurious && res_valid && $urandom_range(0, 3) == 0) begin
        Done   = 1'b1;
        Result = 16'hDEAD;
      end
    end
  end

  // Scoreboard / protocol monitor
  logic [W-1:0] exp_q[$];
  bit           in_op = 1'b0;
  int           op_mode = MNormal;
  int           start_cyc = 0;
  logic [W-1:0] op_a = '0, op_b = '0;
  int           nstart = 0, nres = 0;
  logic [W-1:0] last_res = '0;
  logic         last_err = 1'b0;
  bit           prev_valid = 1'b0;

  initial begin
    logic [W-1:0] e;
    int           exp_r;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_op = 1'b0;
        exp_q.delete();
        prev_valid = 1'b0;
      end else begin
        if (in_valid && in_ready) exp_q.push_back(ref_prod(in_A, in_B));
        if (start) begin
          check("one_start_per_op", in_op, 0);
          in_op = 1'b1;
          op_mode = mode;
          start_cyc = cyc;
          op_a = A;
          op_b = B;
          nstart++;
        end
        if (res_valid && !prev_valid) begin
          case (op_mode)
            MNormal: exp_r = done_cyc + 1;
            MStuck:  exp_r = start_cyc + 3;
            default: exp_r = start_cyc + 2 + int'(TMO);
          endcase
          check("res_latency", cyc, exp_r);
        end
        if (res_valid && res_ready) begin
          check("ab_stable_a", A, op_a);
          check("ab_stable_b", B, op_b);
          if (exp_q.size() == 0) begin
            check("res_unexpected", 0, 1);
          end else begin
            e = exp_q.pop_front();
            if (op_mode == MDead) e = '1;
            check("res_data", res_data, e);
          end
          check("res_err", res_err, (op_mode == MDead) ? 1 : 0);
          last_res = res_data;
          last_err = res_err;
          in_op = 1'b0;
          nres++;
        end
        prev_valid = res_valid;
      end
    end
  end

  // Entered and left at posedge+1.
  task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_A = a;
    in_B = b;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) check("push_accept_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || in_op || res_valid) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_done", (exp_q.size() == 0 && !in_op) ? 1 : 0, 1);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           lat;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int s0, r0, n;
    logic [W-1:0] snap_d, snap_a, snap_b;

    vecs[0] = '{16'h0003, 16'h00F0, 5, 16'h02D0};
    vecs[1] = '{16'h0000, 16'h1234, 2, 16'h0000};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 3, 16'h0001};
    vecs[3] = '{16'h0001, 16'hABCD, 4, 16'hABCD};
    vecs[4] = '{16'h0100, 16'h0100, 6, 16'h0000};
    vecs[5] = '{16'h00FF, 16'h0101, 2, 16'hFFFF};
    vecs[6] = '{16'h1234, 16'h0010, 3, 16'h2340};

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_start", start, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_err", res_err, 0);
    check("rst_A", A, 0);
    check("rst_B", B, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      s0 = nstart;
      mode = MNormal;
      mul_lat = vecs[i].lat;
      push_pair(vecs[i].a, vecs[i].b);
      drain(200);
      check("vec_result", last_res, vecs[i].exp);
      check("vec_one_start", nstart - s0, 1);
    end

    // Reset in the middle of WAIT with a second pair still queued
    mul_lat = 30;
    s0 = nstart;
    push_pair(16'h1111, 16'h2222);
    push_pair(16'h0003, 16'h0004);
    n = 0;
    while (nstart == s0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_op_started", nstart - s0, 1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("rst_mid_start", start, 0);
    check("rst_mid_res_valid", res_valid, 0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    s0 = nstart;
    @(posedge clk); #1;
    check("rst_mid_in_ready", in_ready, 1);
    repeat (40) begin
      @(posedge clk); #1;
    end
    check("rst_mid_flushed", nstart - s0, 0);
    check("rst_mid_no_result", res_valid, 0);

    // Held result plus a full FIFO behind it
    mode = MNormal;
    mul_lat = 3;
    rr_mode = 2;
    r0 = nres;
    push_pair(16'h0011, 16'h0022);
    n = 0;
    while (!res_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_valid_seen", res_valid, 1);
    snap_d = res_data;
    snap_a = A;
    snap_b = B;
    s0 = nstart;
    for (int k = 0; k < 4; k++) push_pair(16'(k + 2), 16'(k + 100));
    @(negedge clk);
    check("fifo_full_in_ready", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_A = 16'h0077;
    in_B = 16'h0009;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold_res_valid", res_valid, 1);
      check("hold_res_data", res_data, snap_d);
      check("hold_A", A, snap_a);
      check("hold_B", B, snap_b);
      check("full_in_ready", in_ready, 0);
    end
    check("hold_no_start", nstart - s0, 0);
    rr_mode = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 30);
    check("pair5_accepted", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain(300);
    check("burst_results", nres - r0, 6);

    // Done stuck high across several ops
    mode = MStuck;
    r0 = nres;
    s0 = nstart;
    push_pair(16'h0005, 16'h0006);
    push_pair(16'h0102, 16'h0304);
    push_pair(16'h8000, 16'h0003);
    drain(200);
    check("stuck_results", nres - r0, 3);
    check("stuck_starts", nstart - s0, 3);
    mode = MNormal;
    repeat (2) begin
      @(posedge clk); #1;
    end

    // Random traffic with backpressure and stray Done pulses in HOLD
    rand_lat = 1'b1;
    rr_mode = 1;
    spurious = 1'b1;
    r0 = nres;
    for (int i = 0; i < 40; i++) begin
      push_pair(16'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    drain(4000);
    check("random_results", nres - r0, 40);
    rand_lat = 1'b0;
    rr_mode = 0;
    spurious = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end

`ifdef MULT_DISPATCH_TMO_EN
    // Done never arrives
    mode = MDead;
    push_pair(16'h0005, 16'h0007);
    drain(int'(TMO) + 100);
    check("tmo_data", last_res, 16'hFFFF);
    check("tmo_err", last_err, 1);
    mode = MNormal;
    mul_lat = 4;
    repeat (2) begin
      @(posedge clk); #1;
    end
    push_pair(16'h0006, 16'h0007);
    drain(100);
    check("after_tmo_data", last_res, 16'h002A);
    check("after_tmo_err", last_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d of %0d passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
